// File: rtl/line_buffer_ctrl_if.sv
// Pixel stream, line-buffer bank and window-word signals of line_buffer_ctrl.
// slave is the controller's view; master is the surrounding datapath's view.
interface line_buffer_ctrl_if #(
   parameter int unsigned NUM_LINES   = 4,
   parameter int unsigned KERNEL_ROWS = 3
);
   localparam int unsigned PIX_W = 8;
   localparam int unsigned TAP_W = 3 * PIX_W;

   logic                         i_valid;
   logic [PIX_W-1:0]             i_data;
   logic                         o_ready;
   logic [NUM_LINES-1:0]         o_lb_wr_valid;
   logic [PIX_W-1:0]             o_lb_wr_data;
   logic [NUM_LINES-1:0]         o_lb_rd_en;
   logic [TAP_W*NUM_LINES-1:0]   i_lb_rd_data;
   logic                         o_valid;
   logic [TAP_W*KERNEL_ROWS-1:0] o_data;
   logic                         i_ready;
   logic                         o_intr;

   modport slave (
      input  i_valid, i_data, i_lb_rd_data, i_ready,
      output o_ready, o_lb_wr_valid, o_lb_wr_data, o_lb_rd_en, o_valid, o_data, o_intr
   );

   modport master (
      output i_valid, i_data, i_lb_rd_data, i_ready,
      input  o_ready, o_lb_wr_valid, o_lb_wr_data, o_lb_rd_en, o_valid, o_data, o_intr
   );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Round-robin write steering and lock-step KERNEL_ROWS read sequencing
// over a bank of single-line buffers feeding a sliding-window filter.
module line_buffer_ctrl #(
   parameter int unsigned LINE_WIDTH  = 512,
   parameter int unsigned NUM_LINES   = 4,
   parameter int unsigned KERNEL_ROWS = 3
) (
   input logic                i_clk,
   input logic                i_reset,
   line_buffer_ctrl_if.slave  bus
);
   localparam int unsigned TAP_W = 24;
   localparam int unsigned CW    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int unsigned SW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int unsigned FW    = $clog2(NUM_LINES + 1);

   typedef enum logic {ST_IDLE, ST_READ} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [SW-1:0]   wr_sel_q, wr_sel_d;
   logic [SW-1:0]   rd_sel_q, rd_sel_d;
   logic [FW-1:0]   lines_full_q, lines_full_d;
   logic            intr_q, intr_d;

   logic            accept_c, handshake_c, wr_done_c, release_c;
   logic [TAP_W-1:0] rd_slice [NUM_LINES];

   function automatic logic [SW-1:0] sel_inc(input logic [SW-1:0] sel);
      return (sel == SW'(NUM_LINES - 1)) ? '0 : sel + SW'(1);
   endfunction

   for (genvar k = 0; k < NUM_LINES; k++) begin : g_slice
      assign rd_slice[k] = bus.i_lb_rd_data[TAP_W*k +: TAP_W];
   end

   // Handshake qualifiers and line-boundary events
   always_comb begin
      bus.o_ready  = !i_reset && (lines_full_q < FW'(NUM_LINES));
      bus.o_valid  = !i_reset && (state_q == ST_READ);
      accept_c     = bus.i_valid && bus.o_ready;
      handshake_c  = bus.o_valid && bus.i_ready;
      wr_done_c    = accept_c && (wr_cnt_q == CW'(LINE_WIDTH - 1));
      release_c    = handshake_c && (rd_cnt_q == CW'(LINE_WIDTH - 1));
   end

   always_comb begin
      bus.o_lb_wr_valid = '0;
      bus.o_lb_wr_data  = bus.i_data;
      if (accept_c) begin
         bus.o_lb_wr_valid[wr_sel_q] = 1'b1;
      end
   end

   // Window row r comes from buffer (rd_sel + r) mod NUM_LINES
   always_comb begin
      logic [SW-1:0] idx;
      idx            = '0;
      bus.o_data     = '0;
      bus.o_lb_rd_en = '0;
      for (int unsigned r = 0; r < KERNEL_ROWS; r++) begin
         idx = SW'((32'(rd_sel_q) + r) % NUM_LINES);
         if (bus.o_valid) begin
            bus.o_data[TAP_W*r +: TAP_W] = rd_slice[idx];
         end
         if (handshake_c) begin
            bus.o_lb_rd_en[idx] = 1'b1;
         end
      end
   end

   assign bus.o_intr = intr_q;

   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      wr_sel_d     = wr_sel_q;
      rd_cnt_d     = rd_cnt_q;
      rd_sel_d     = rd_sel_q;
      lines_full_d = lines_full_q;
      intr_d       = release_c;

      if (accept_c) begin
         if (wr_done_c) begin
            wr_cnt_d = '0;
            wr_sel_d = sel_inc(wr_sel_q);
         end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
         end
      end

      if (handshake_c) begin
         if (release_c) begin
            rd_cnt_d = '0;
            rd_sel_d = sel_inc(rd_sel_q);
         end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
         end
      end

      // Simultaneous fill and release leave the occupancy unchanged
      if (wr_done_c && !release_c) begin
         lines_full_d = lines_full_q + FW'(1);
      end else if (release_c && !wr_done_c) begin
         lines_full_d = lines_full_q - FW'(1);
      end

      unique case (state_q)
         ST_IDLE: if (lines_full_q >= FW'(KERNEL_ROWS)) state_d = ST_READ;
         ST_READ: if (release_c) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         wr_cnt_q     <= '0;
         wr_sel_q     <= '0;
         rd_cnt_q     <= '0;
         rd_sel_q     <= '0;
         lines_full_q <= '0;
         intr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         wr_sel_q     <= wr_sel_d;
         rd_cnt_q     <= rd_cnt_d;
         rd_sel_q     <= rd_sel_d;
         lines_full_q <= lines_full_d;
         intr_q       <= intr_d;
      end
   end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: behavioural line buffers, a line/window level
// reference model feeding an expected-window queue, and a read-side monitor.
module tb_line_buffer_ctrl;
   localparam int unsigned LW = 8;
   localparam int unsigned NL = 4;
   localparam int unsigned KR = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   line_buffer_ctrl_if #(.NUM_LINES(NL), .KERNEL_ROWS(KR)) bus ();

   line_buffer_ctrl #(.LINE_WIDTH(LW), .NUM_LINES(NL), .KERNEL_ROWS(KR)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Behavioural line buffers: output is the 3-pixel tap at the read pointer
   logic [7:0] mem [NL][LW];
   int         wp [NL];
   int         rp [NL];

   always @(posedge clk) begin
      for (int k = 0; k < NL; k++) begin
         if (rst) begin
            wp[k] <= 0;
            rp[k] <= 0;
         end else begin
            if (bus.o_lb_wr_valid[k]) begin
               mem[k][wp[k]] <= bus.o_lb_wr_data;
               wp[k]         <= (wp[k] + 1) % LW;
            end
            if (bus.o_lb_rd_en[k]) rp[k] <= (rp[k] + 1) % LW;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NL; k++) begin
         bus.i_lb_rd_data[24*k +: 24] = {mem[k][(rp[k] + 2) % LW],
                                         mem[k][(rp[k] + 1) % LW],
                                         mem[k][rp[k]]};
      end
   end

   typedef struct {
      logic [71:0] data;
      logic [3:0]  mask;
   } exp_t;

   exp_t       q[$];
   logic [7:0] px [256][LW];
   int         done_cyc [256];
   int         cyc = 0;
   int         acc = 0;
   int         lines_done = 0;
   int         released = 0;
   int         hs_cnt = 0;
   int         last_rel = -100;
   bit         prev_rel = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         rdy_mode = 1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Write-side predictor: line n goes to buffer n mod NL; a completed line
   // n+KR-1 makes window row n available, one word per column
   always @(negedge clk) begin
      int   ln, col;
      exp_t e;
      if (rst) begin
         acc        <= 0;
         lines_done <= 0;
      end else if (bus.i_valid && bus.o_ready) begin
         ln  = acc / LW;
         col = acc % LW;
         chk("wr_valid", 72'(bus.o_lb_wr_valid), 72'(1 << (ln % NL)));
         chk("wr_data", 72'(bus.o_lb_wr_data), 72'(bus.i_data));
         px[ln][col] = bus.i_data;
         acc <= acc + 1;
         if (col == LW - 1) begin
            lines_done   <= lines_done + 1;
            done_cyc[ln] <= cyc;
            if (ln >= KR - 1) begin
               for (int c = 0; c < LW; c++) begin
                  e.data = '0;
                  e.mask = '0;
                  for (int r = 0; r < KR; r++) begin
                     e.data[24*r +: 24] = {px[ln-KR+1+r][(c+2) % LW],
                                           px[ln-KR+1+r][(c+1) % LW],
                                           px[ln-KR+1+r][c]};
                     e.mask[(ln - KR + 1 + r) % NL] = 1'b1;
                  end
                  q.push_back(e);
               end
            end
         end
      end else begin
         chk("wr_valid_idle", 72'(bus.o_lb_wr_valid), 72'(0));
      end
   end

   // Read-side monitor: a row becomes readable two edges after both its last
   // line landed and the previous row was released
   always @(negedge clk) begin
      bit have, exp_valid, rel;
      int mx;
      if (rst) begin
         q.delete();
         released = 0;
         hs_cnt   = 0;
         last_rel = -100;
         prev_rel = 1'b0;
      end else begin
         have      = lines_done >= released + KR;
         exp_valid = 1'b0;
         if (have) begin
            mx        = (done_cyc[released + KR - 1] > last_rel) ? done_cyc[released + KR - 1] : last_rel;
            exp_valid = cyc >= mx + 2;
         end
         chk("o_ready", 72'(bus.o_ready), 72'((lines_done - released) < NL));
         chk("o_valid", 72'(bus.o_valid), 72'(exp_valid));
         chk("o_intr", 72'(bus.o_intr), 72'(prev_rel));
         rel = 1'b0;
         if (bus.o_valid) begin
            if (q.size() == 0) begin
               fail_now("window_without_expectation");
            end else begin
               chk("o_data", bus.o_data, q[0].data);
               if (bus.i_ready) begin
                  chk("rd_en", 72'(bus.o_lb_rd_en), 72'(q[0].mask));
                  void'(q.pop_front());
                  hs_cnt++;
                  if (hs_cnt == LW) begin
                     hs_cnt   = 0;
                     released++;
                     last_rel = cyc;
                     rel      = 1'b1;
                  end
               end else begin
                  chk("rd_en_stall", 72'(bus.o_lb_rd_en), 72'(0));
               end
            end
         end else begin
            chk("o_data_idle", bus.o_data, 72'(0));
            chk("rd_en_idle", 72'(bus.o_lb_rd_en), 72'(0));
         end
         prev_rel = rel;
      end
   end

   // Downstream ready: 0 hold, 1 always, 2 random, 3 pattern 1,0,0,1
   initial begin
      logic [3:0] pat;
      int pi;
      pat = 4'b1001;
      pi  = 0;
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.i_ready = 1'b0;
            1:       bus.i_ready = 1'b1;
            2:       bus.i_ready = 1'($urandom_range(0, 1));
            default: begin bus.i_ready = pat[3 - (pi % 4)]; pi++; end
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixels(input int n, input int max_gap, input int budget, input bit must_take);
      bit got;
      for (int i = 0; i < n; i++) begin
         bus.i_valid = 1'b0;
         repeat ($urandom_range(0, max_gap)) step();
         bus.i_valid = 1'b1;
         bus.i_data  = 8'($urandom);
         got = 1'b0;
         for (int w = 0; w < budget && !got; w++) begin
            @(negedge clk);
            got = bus.o_ready;
            step();
         end
         if (!got && must_take) fail_now("pixel_accept_timeout");
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int w;
      for (w = 0; w < budget; w++) begin
         if (q.size() == 0 && hs_cnt == 0) break;
         step();
      end
      if (w == budget) fail_now("drain_timeout");
      repeat (3) step();
   endtask

   task automatic do_reset();
      bus.i_valid = 1'b0;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
   endtask

   initial begin
      int w;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      rst         = 1'b1;
      step();
      do_reset();
      repeat (3) step();

      // Three lines back to back, downstream always ready
      rdy_mode = 1;
      send_pixels(24, 0, 50, 1'b1);
      wait_drain(200);

      // Downstream stalled: bank fills, extra pixels refused
      do_reset();
      rdy_mode = 0;
      send_pixels(32, 0, 50, 1'b1);
      send_pixels(8, 0, 6, 1'b0);
      repeat (5) step();
      rdy_mode = 3;
      wait_drain(400);

      // Two more lines so a window wraps across buffers 3,0,1
      rdy_mode = 2;
      send_pixels(16, 1, 200, 1'b1);
      wait_drain(400);

      // Last read handshake lands on the same edge as a line completion
      do_reset();
      rdy_mode = 1;
      send_pixels(24, 0, 50, 1'b1);
      step();
      send_pixels(8, 0, 50, 1'b1);
      wait_drain(200);

      // Random traffic, then a reset while a window row is being read
      rdy_mode = 2;
      send_pixels(48, 2, 300, 1'b1);
      for (w = 0; w < 300; w++) begin
         @(negedge clk);
         if (bus.o_valid) break;
      end
      if (w == 300) fail_now("valid_timeout");
      step();
      do_reset();
      repeat (2) step();
      send_pixels(80, 2, 300, 1'b1);
      wait_drain(1000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end
endmodule
